// File: rtl/uart_rx_pkg.sv
// Shared definitions for the memory-mapped UART receiver: register map,
// register bit positions and receive FSM states.
package uart_rx_pkg;

    localparam logic [1:0] RegRxdata = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;
    localparam logic [1:0] RegCtrl   = 2'd3;

    localparam int unsigned StatAvail   = 0;
    localparam int unsigned StatFull    = 1;
    localparam int unsigned StatOverrun = 2;
    localparam int unsigned StatFerr    = 3;

    localparam int unsigned CtrlRxEn  = 0;
    localparam int unsigned CtrlIrqEn = 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with wrapping pointers and an occupancy count.
// A pop on empty is ignored; a push on full only lands if a pop frees a slot.
module uart_rx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int unsigned Depth = 2 ** AW;

    logic [7:0]    mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW + 1)'(Depth));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: rxd synchroniser, receive FSM, RX FIFO,
// status/control registers on the shared CPU bus and a level interrupt.
module uart_rx_mmio
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 2604,
    parameter int unsigned FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst_,
    inout  wire  [7:0] data,
    input  logic [7:0] addr,
    input  logic       cs_,
    input  logic       oe_,
    input  logic       we_,
    input  logic       rxd,
    output logic       interrupt
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    logic            rxd_meta_q, rxd_s_q;
    logic            rx_en_q, irq_en_q, overrun_q, ferr_q, rd_q, irq_q;
    rx_state_e       state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            push, ferr_set;

    logic [7:0]       fifo_dout;
    logic             fifo_empty, fifo_full;
    logic [FIFO_AW:0] fifo_count;

    logic       reg_sel, wr, rd_rxdata, pop, ovr_set;
    logic [7:0] rdata;

    assign reg_sel   = (addr[7:2] == 6'd0);
    assign wr        = ~cs_ & ~we_ & reg_sel;
    assign rd_rxdata = ~cs_ & ~oe_ & reg_sel & (addr[1:0] == RegRxdata);
    // Pop once, as the RXDATA read access ends.
    assign pop       = rd_q & ~rd_rxdata;
    assign ovr_set   = push & fifo_full & ~pop;

    uart_rx_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (push),
        .din   (shreg_q),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rx_en_q    <= 1'b1;
            irq_en_q   <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            rd_q       <= 1'b0;
            irq_q      <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            shreg_q    <= '0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_s_q    <= rxd_meta_q;
            rd_q       <= rd_rxdata;
            if (wr && addr[1:0] == RegCtrl) begin
                rx_en_q  <= data[CtrlRxEn];
                irq_en_q <= data[CtrlIrqEn];
            end
            overrun_q <= ovr_set | (overrun_q &
                         ~(wr && addr[1:0] == RegStatus && data[StatOverrun]));
            ferr_q    <= ferr_set | (ferr_q &
                         ~(wr && addr[1:0] == RegStatus && data[StatFerr]));
            irq_q     <= irq_en_q & (~fifo_empty | overrun_q | ferr_q);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (!rx_en_q) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!rxd_s_q) begin
                        state_d = StStart;
                        cnt_d   = CntW'(CLKS_PER_BIT / 2 - 1);
                    end
                end
                StStart: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (rxd_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = '0;
                        cnt_d   = CntW'(CLKS_PER_BIT - 1);
                    end
                end
                StData: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        shreg_d = {rxd_s_q, shreg_q[7:1]};
                        cnt_d   = CntW'(CLKS_PER_BIT - 1);
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == 3'd7) state_d = StStop;
                    end
                end
                StStop: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (rxd_s_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = StBreak;
                    end
                end
                StBreak: begin
                    if (rxd_s_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (reg_sel) begin
            case (addr[1:0])
                RegRxdata: rdata = fifo_empty ? 8'h00 : fifo_dout;
                RegStatus: begin
                    rdata[StatAvail]   = ~fifo_empty;
                    rdata[StatFull]    = fifo_full;
                    rdata[StatOverrun] = overrun_q;
                    rdata[StatFerr]    = ferr_q;
                end
                RegCount:  rdata[FIFO_AW:0] = fifo_count;
                RegCtrl: begin
                    rdata[CtrlRxEn]  = rx_en_q;
                    rdata[CtrlIrqEn] = irq_en_q;
                end
                default:   rdata = '0;
            endcase
        end
    end

    assign data      = (~cs_ & ~oe_) ? rdata : {8{1'bz}};
    assign interrupt = irq_q;

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Self-checking bench for uart_rx_mmio: table of single frames plus hand-written
// glitch, overflow, framing, interrupt and mid-frame reset sequences.
module tb_uart_rx_mmio;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       rst_;
    logic [7:0] addr;
    logic       cs_, oe_, we_, rxd;
    logic [7:0] drv;
    logic       den;
    wire  [7:0] data;
    logic       interrupt;

    int checks   = 0;
    int failures = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] din;
        logic       stop_ok;
        logic [7:0] exp_status;
        logic [7:0] exp_count;
    } vec_t;

    vec_t vecs[5];

    assign data = den ? drv : {8{1'bz}};

    always #5 clk = ~clk;

    uart_rx_mmio #(
        .CLKS_PER_BIT (Cpb),
        .FIFO_AW      (4)
    ) dut (
        .clk       (clk),
        .rst_      (rst_),
        .data      (data),
        .addr      (addr),
        .cs_       (cs_),
        .oe_       (oe_),
        .we_       (we_),
        .rxd       (rxd),
        .interrupt (interrupt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two-cycle access so the RXDATA read flag is seen by a rising edge.
    task automatic reg_read(input logic [7:0] a, output logic [7:0] v);
        addr = a;
        cs_  = 1'b0;
        oe_  = 1'b0;
        @(negedge clk);
        v   = data;
        cs_ = 1'b1;
        oe_ = 1'b1;
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] v);
        addr = a;
        drv  = v;
        den  = 1'b1;
        cs_  = 1'b0;
        we_  = 1'b0;
        @(negedge clk);
        cs_ = 1'b1;
        we_ = 1'b1;
        den = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        reg_read(a, v);
        chk(name, v, exp);
    endtask

    task automatic check_rx(input string name);
        logic [7:0] v;
        logic [7:0] exp;
        exp = 8'h00;
        if (sb.size() != 0) exp = sb.pop_front();
        reg_read(8'h00, v);
        chk(name, v, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int stop_len,
                              input logic expect_push);
        rxd = 1'b0;
        clks(Cpb);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(Cpb);
        end
        rxd = stop_ok;
        clks(stop_ok ? Cpb : stop_len);
        rxd = 1'b1;
        clks(4);
        if (expect_push) sb.push_back(b);
    endtask

    initial begin
        logic [7:0] v;
        vecs[0] = '{din: 8'hA5, stop_ok: 1'b1, exp_status: 8'h01, exp_count: 8'h01};
        vecs[1] = '{din: 8'h00, stop_ok: 1'b1, exp_status: 8'h01, exp_count: 8'h01};
        vecs[2] = '{din: 8'hFF, stop_ok: 1'b1, exp_status: 8'h01, exp_count: 8'h01};
        vecs[3] = '{din: 8'h3C, stop_ok: 1'b0, exp_status: 8'h08, exp_count: 8'h00};
        vecs[4] = '{din: 8'h5A, stop_ok: 1'b1, exp_status: 8'h01, exp_count: 8'h01};

        rst_ = 1'b0;
        rxd  = 1'b1;
        cs_  = 1'b1;
        oe_  = 1'b1;
        we_  = 1'b1;
        den  = 1'b0;
        drv  = 8'h00;
        addr = 8'h00;
        clks(3);
        chk("reset_irq", interrupt, 1'b0);
        rst_ = 1'b1;
        clks(2);
        check_reg("reset_status", 8'h01, 8'h00);
        check_reg("reset_count", 8'h02, 8'h00);
        check_reg("reset_ctrl", 8'h03, 8'h01);
        check_reg("reset_rxdata", 8'h00, 8'h00);

        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].din, vecs[i].stop_ok, 40, vecs[i].stop_ok);
            check_reg($sformatf("vec%0d_status", i), 8'h01, vecs[i].exp_status);
            check_reg($sformatf("vec%0d_count", i), 8'h02, vecs[i].exp_count);
            if (vecs[i].exp_count != 8'h00) check_rx($sformatf("vec%0d_rxdata", i));
            check_reg($sformatf("vec%0d_count_after", i), 8'h02, 8'h00);
            reg_write(8'h01, 8'h0C);
            check_reg($sformatf("vec%0d_status_after", i), 8'h01, 8'h00);
        end

        // Glitch shorter than half a bit must not start a frame.
        rxd = 1'b0;
        clks(4);
        rxd = 1'b1;
        clks(40);
        check_reg("glitch_status", 8'h01, 8'h00);
        check_reg("glitch_count", 8'h02, 8'h00);

        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1, 0, i < 16);
        end
        check_reg("ovf_count", 8'h02, 8'h10);
        check_reg("ovf_status", 8'h01, 8'h07);
        for (int i = 0; i < 16; i++) check_rx($sformatf("ovf_rx%0d", i));
        check_reg("ovf_status_drained", 8'h01, 8'h04);
        reg_write(8'h01, 8'h04);
        check_reg("ovf_status_cleared", 8'h01, 8'h00);

        send_frame(8'h3C, 1'b0, 40, 1'b0);
        check_reg("ferr_status", 8'h01, 8'h08);
        check_reg("ferr_count", 8'h02, 8'h00);
        send_frame(8'h55, 1'b1, 0, 1'b1);
        check_reg("ferr_status_next", 8'h01, 8'h09);
        check_rx("ferr_rx55");
        reg_write(8'h01, 8'h08);
        check_reg("ferr_cleared", 8'h01, 8'h00);

        check_reg("unmapped_read", 8'h04, 8'h00);

        reg_write(8'h03, 8'h03);
        check_reg("ctrl_rw", 8'h03, 8'h03);
        send_frame(8'h11, 1'b1, 0, 1'b1);
        chk("irq_set", interrupt, 1'b1);
        check_rx("irq_rx11");
        chk("irq_at_pop", interrupt, 1'b1);
        clks(1);
        chk("irq_cleared", interrupt, 1'b0);

        reg_write(8'h03, 8'h01);
        send_frame(8'h11, 1'b1, 0, 1'b1);
        chk("irq_masked", interrupt, 1'b0);
        check_rx("irq_masked_rx");

        reg_write(8'h03, 8'h03);
        send_frame(8'h22, 1'b1, 0, 1'b1);
        chk("pre_reset_irq", interrupt, 1'b1);
        rxd = 1'b0;
        clks(Cpb);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            clks(Cpb);
        end
        rxd = 1'b0;
        clks(Cpb / 2);
        rst_ = 1'b0;
        #1;
        chk("midreset_irq", interrupt, 1'b0);
        clks(1);
        check_reg("midreset_count", 8'h02, 8'h00);
        check_reg("midreset_ctrl", 8'h03, 8'h01);
        rst_ = 1'b1;
        rxd  = 1'b1;
        sb.delete();
        clks(100);
        send_frame(8'h7E, 1'b1, 0, 1'b1);
        check_reg("post_reset_status", 8'h01, 8'h01);
        check_rx("post_reset_rx7e");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
